// File: rtl/image_pkg.sv
// Shared types and defaults for the image RAM write path.
// Capture FSM states and frame geometry helpers.
package image_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    WRITE,
    DONE
  } state_t;

  localparam int DEF_WIDTH      = 320;
  localparam int DEF_HEIGHT     = 240;
  localparam int DEF_DATA_WIDTH = 8;

  function automatic int frame_pixels(
    input int w = DEF_WIDTH,
    input int h = DEF_HEIGHT
  );
    return w * h;
  endfunction

endpackage

// File: rtl/raster_addr_counter.sv
// Column / row / linear address counters for raster writes.
// Linear address is built by increments and a row base, no multiplier.
module raster_addr_counter
  import image_pkg::*;
#(
  parameter  int ADDR_WIDTH   = 17,
  parameter  int IMAGE_WIDTH  = DEF_WIDTH,
  parameter  int IMAGE_HEIGHT = DEF_HEIGHT,
  localparam int CW = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1,
  localparam int RW = $clog2(IMAGE_HEIGHT + 1)
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  clear,
  input  logic                  step,
  input  logic                  force_next_line,
  output logic [CW-1:0]         col,
  output logic [RW-1:0]         row,
  output logic [ADDR_WIDTH-1:0] lin,
  output logic                  last_col,
  output logic                  last_pixel
);

  localparam logic [ADDR_WIDTH-1:0] LAST_LIN =
    ADDR_WIDTH'(frame_pixels(IMAGE_WIDTH, IMAGE_HEIGHT) - 1);

  logic [ADDR_WIDTH-1:0] rbase;

  assign last_col   = (col == CW'(IMAGE_WIDTH - 1));
  assign last_pixel = (lin == LAST_LIN);

  // clear loads the state that follows the sof pixel at address 0
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      col   <= '0;
      row   <= '0;
      lin   <= '0;
      rbase <= '0;
    end else if (clear) begin
      col   <= CW'(1);
      row   <= '0;
      lin   <= ADDR_WIDTH'(1);
      rbase <= '0;
    end else if (force_next_line) begin
      col   <= '0;
      row   <= row + RW'(1);
      rbase <= rbase + ADDR_WIDTH'(IMAGE_WIDTH);
      lin   <= rbase + ADDR_WIDTH'(IMAGE_WIDTH);
    end else if (step) begin
      lin <= lin + ADDR_WIDTH'(1);
      if (last_col) begin
        col   <= '0;
        row   <= row + RW'(1);
        rbase <= rbase + ADDR_WIDTH'(IMAGE_WIDTH);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

endmodule

// File: rtl/image_frame_writer.sv
// Raster pixel stream to image RAM write port, with frame/line checks.
// Optional IMAGE_DOUBLE_BUFFER_EN adds ping-pong banks for the reader.
module image_frame_writer
  import image_pkg::*;
#(
  parameter int ADDR_WIDTH   = 17,
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int IMAGE_WIDTH  = DEF_WIDTH,
  parameter int IMAGE_HEIGHT = DEF_HEIGHT
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  continuous,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  input  logic                  in_sof,
  input  logic                  in_eol,
  output logic                  in_ready,
`ifdef IMAGE_DOUBLE_BUFFER_EN
  output logic [ADDR_WIDTH:0]   wraddress,
  output logic                  bank_sel,
  output logic                  rd_bank,
`else
  output logic [ADDR_WIDTH-1:0] wraddress,
`endif
  output logic [DATA_WIDTH-1:0] data,
  output logic                  we,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  line_error
);

  localparam int CW = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;
  localparam int RW = $clog2(IMAGE_HEIGHT + 1);

  state_t                state;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [CW-1:0]         col;
  logic [RW-1:0]         row;
  logic [ADDR_WIDTH-1:0] lin;
  logic                  last_col;
  logic                  last_pixel;

  logic acc, clr, w_beat, early, missing, last_row, fwd, stp;

  assign acc      = in_valid & in_ready;
  assign clr      = acc & in_sof & (state == ARMED || state == WRITE);
  assign w_beat   = acc & ~in_sof & (state == WRITE);
  assign early    = w_beat & in_eol & (col != CW'(IMAGE_WIDTH - 1));
  assign missing  = w_beat & ~in_eol & last_col;
  assign last_row = (row == RW'(IMAGE_HEIGHT - 1));
  // an early eol on the final line ends the frame instead of running past it
  assign fwd      = early & ~last_row;
  assign stp      = w_beat & ~early;

`ifdef IMAGE_DOUBLE_BUFFER_EN
  assign wraddress = {bank_sel, wr_addr};
`else
  assign wraddress = wr_addr;
`endif

  raster_addr_counter #(
    .ADDR_WIDTH   (ADDR_WIDTH),
    .IMAGE_WIDTH  (IMAGE_WIDTH),
    .IMAGE_HEIGHT (IMAGE_HEIGHT)
  ) u_cnt (
    .clock           (clock),
    .reset_n         (reset_n),
    .clear           (clr),
    .step            (stp),
    .force_next_line (fwd),
    .col             (col),
    .row             (row),
    .lin             (lin),
    .last_col        (last_col),
    .last_pixel      (last_pixel)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      in_ready   <= 1'b0;
      wr_addr    <= '0;
      data       <= '0;
      we         <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      line_error <= 1'b0;
`ifdef IMAGE_DOUBLE_BUFFER_EN
      bank_sel   <= 1'b0;
      rd_bank    <= 1'b1;
`endif
    end else begin
      we         <= clr | w_beat;
      frame_done <= 1'b0;
      if (clr | w_beat) begin
        wr_addr <= clr ? '0 : lin;
        data    <= in_data;
      end
      if (start) line_error <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state    <= ARMED;
            in_ready <= 1'b1;
            busy     <= 1'b1;
          end
        end
        ARMED: begin
          if (clr) state <= WRITE;
        end
        WRITE: begin
          if (clr) begin
            line_error <= 1'b1;
          end else if (w_beat) begin
            if (early | missing) line_error <= 1'b1;
            if (last_pixel | (early & last_row)) begin
              state      <= DONE;
              in_ready   <= 1'b0;
              busy       <= 1'b0;
              frame_done <= 1'b1;
            end
          end
        end
        DONE: begin
          state    <= continuous ? ARMED : IDLE;
          in_ready <= continuous;
          busy     <= continuous;
`ifdef IMAGE_DOUBLE_BUFFER_EN
          bank_sel <= ~bank_sel;
          rd_bank  <= ~rd_bank;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_image_frame_writer.sv
// Directed bench for image_frame_writer on a 4x3 frame.
module tb_image_frame_writer;

  localparam int AW = 4;
  localparam int DW = 8;
  localparam int W  = 4;
  localparam int H  = 3;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic          continuous = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_sof = 1'b0;
  logic          in_eol = 1'b0;
  logic          in_ready;
`ifdef IMAGE_DOUBLE_BUFFER_EN
  logic [AW:0]   wraddress;
  logic          bank_sel;
  logic          rd_bank;
`else
  logic [AW-1:0] wraddress;
`endif
  logic [DW-1:0] data;
  logic          we;
  logic          busy;
  logic          frame_done;
  logic          line_error;

  int checks = 0;
  int fails  = 0;

  logic [AW-1:0] log_a [$];
  logic [DW-1:0] log_d [$];
  int            done_cnt = 0;
  int            lat_bad = 0;
  logic          acc_q;

  always #5 clock = ~clock;

  image_frame_writer #(
    .ADDR_WIDTH   (AW),
    .DATA_WIDTH   (DW),
    .IMAGE_WIDTH  (W),
    .IMAGE_HEIGHT (H)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .start      (start),
    .continuous (continuous),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_sof     (in_sof),
    .in_eol     (in_eol),
    .in_ready   (in_ready),
`ifdef IMAGE_DOUBLE_BUFFER_EN
    .bank_sel   (bank_sel),
    .rd_bank    (rd_bank),
`endif
    .wraddress  (wraddress),
    .data       (data),
    .we         (we),
    .busy       (busy),
    .frame_done (frame_done),
    .line_error (line_error)
  );

  always @(posedge clock or negedge reset_n)
    if (!reset_n) acc_q <= 1'b0;
    else acc_q <= in_valid & in_ready;

  always @(negedge clock) begin
    if (we) begin
      log_a.push_back(wraddress[AW-1:0]);
      log_d.push_back(data);
      if (!acc_q) lat_bad++;
    end
    if (frame_done) done_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired busy=%b required=finish", busy);
    $fatal(1);
  end

  task automatic pulse_start;
    @(negedge clock) start = 1'b1;
    @(negedge clock) start = 1'b0;
  endtask

  task automatic beat(input logic [DW-1:0] d, input logic sof,
                      input logic eol, input int gap);
    int n;
    repeat (gap) @(negedge clock);
    @(negedge clock);
    in_valid = 1'b1;
    in_data  = d;
    in_sof   = sof;
    in_eol   = eol;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clock);
      n++;
    end
    if (n >= 20) begin
      checks++;
      fails++;
      $display("FAIL beat_timeout in_ready=%b required=1", in_ready);
    end else begin
      @(posedge clock);
    end
    #1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    in_eol   = 1'b0;
  endtask

  task automatic send_frame(input logic [DW-1:0] base, input int maxgap);
    for (int i = 0; i < W * H; i++)
      beat(base + DW'(i), i == 0, (i % W) == W - 1,
           int'($urandom_range(maxgap, 0)));
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    checks++;
    if ({we, in_ready, busy, frame_done, line_error} !== 5'b0) begin
      fails++;
      $display("FAIL reset_flags got=%b required=00000",
               {we, in_ready, busy, frame_done, line_error});
    end
    checks++;
    if (wraddress[AW-1:0] !== '0 || data !== '0) begin
      fails++;
      $display("FAIL reset_bus addr=%0d data=%0h required=0/0",
               wraddress[AW-1:0], data);
    end
`ifdef IMAGE_DOUBLE_BUFFER_EN
    checks++;
    if (bank_sel !== 1'b0 || rd_bank !== 1'b1) begin
      fails++;
      $display("FAIL reset_bank got=%b%b required=01", bank_sel, rd_bank);
    end
`endif
    @(negedge clock) reset_n = 1'b1;
  endtask

  task automatic test_nominal;
    int b, dc;
    b  = log_a.size();
    dc = done_cnt;
    pulse_start;
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL nom_armed busy/ready=%b%b required=11", busy, in_ready);
    end
    beat(8'h10, 1'b1, 1'b0, 0);
    @(negedge clock);
    checks++;
    if (we !== 1'b1 || wraddress[AW-1:0] !== '0 || data !== 8'h10) begin
      fails++;
      $display("FAIL nom_latency we=%b addr=%0d data=%0h required=1/0/10",
               we, wraddress[AW-1:0], data);
    end
    for (int i = 1; i < W * H; i++)
      beat(8'h10 + DW'(i), 1'b0, (i % W) == W - 1, 0);
    repeat (3) @(negedge clock);
    checks++;
    if (log_a.size() - b != 12) begin
      fails++;
      $display("FAIL nom_count got=%0d required=12", log_a.size() - b);
    end else begin
      for (int i = 0; i < 12; i++) begin
        checks++;
        if (log_a[b+i] !== AW'(i) || log_d[b+i] !== 8'h10 + DW'(i)) begin
          fails++;
          $display("FAIL nom_write%0d addr=%0d data=%0h required=%0d/%0h",
                   i, log_a[b+i], log_d[b+i], i, 8'h10 + i);
        end
      end
    end
    checks++;
    if (done_cnt - dc != 1) begin
      fails++;
      $display("FAIL nom_done got=%0d required=1", done_cnt - dc);
    end
    checks++;
    if ({line_error, busy, in_ready} !== 3'b000) begin
      fails++;
      $display("FAIL nom_idle err/busy/ready=%b required=000",
               {line_error, busy, in_ready});
    end
  endtask

  task automatic test_junk;
    int b;
    b = log_a.size();
    pulse_start;
    for (int i = 0; i < 3; i++) beat(8'hA0 + DW'(i), 1'b0, 1'b0, 0);
    repeat (2) @(negedge clock);
    checks++;
    if (log_a.size() != b) begin
      fails++;
      $display("FAIL junk_nowrite got=%0d required=0", log_a.size() - b);
    end
    send_frame(8'h20, 0);
    repeat (3) @(negedge clock);
    checks++;
    if (log_a.size() - b != 12 || log_a[b] !== '0 || log_d[b] !== 8'h20) begin
      fails++;
      $display("FAIL junk_first n=%0d addr=%0d data=%0h required=12/0/20",
               log_a.size() - b, log_a[b], log_d[b]);
    end
  endtask

  task automatic test_backpressure;
    int b, lb, bad;
    b   = log_a.size();
    lb  = lat_bad;
    bad = 0;
    pulse_start;
    send_frame(8'h30, 3);
    repeat (3) @(negedge clock);
    for (int i = 0; i < 12; i++)
      if (log_a[b+i] !== AW'(i) || log_d[b+i] !== 8'h30 + DW'(i)) bad++;
    checks++;
    if (log_a.size() - b != 12 || bad != 0) begin
      fails++;
      $display("FAIL bp_contig n=%0d bad=%0d required=12/0",
               log_a.size() - b, bad);
    end
    checks++;
    if (lat_bad != lb) begin
      fails++;
      $display("FAIL bp_noaccept_write got=%0d required=0", lat_bad - lb);
    end
  endtask

  task automatic test_early_eol;
    int b, dc;
    int exp_a [10] = '{0, 1, 2, 3, 4, 5, 8, 9, 10, 11};
    b  = log_a.size();
    dc = done_cnt;
    pulse_start;
    for (int k = 0; k < 10; k++) begin
      beat(8'h50 + DW'(k), k == 0, k == 3 || k == 5 || k == 9, 0);
      if (k == 4) begin
        @(negedge clock);
        checks++;
        if (line_error !== 1'b0) begin
          fails++;
          $display("FAIL eol_before got=%b required=0", line_error);
        end
      end
    end
    repeat (3) @(negedge clock);
    for (int k = 0; k < 10; k++) begin
      checks++;
      if (log_a[b+k] !== AW'(exp_a[k]) || log_d[b+k] !== 8'h50 + DW'(k)) begin
        fails++;
        $display("FAIL eol_write%0d addr=%0d data=%0h required=%0d/%0h",
                 k, log_a[b+k], log_d[b+k], exp_a[k], 8'h50 + k);
      end
    end
    checks++;
    if (line_error !== 1'b1 || done_cnt - dc != 1) begin
      fails++;
      $display("FAIL eol_flag err=%b done=%0d required=1/1",
               line_error, done_cnt - dc);
    end
    pulse_start;
    checks++;
    if (line_error !== 1'b0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL eol_clear err=%b busy=%b required=0/1", line_error, busy);
    end
  endtask

  task automatic test_midsof_cont;
    int b, dc;
    continuous = 1'b1;
    b  = log_a.size();
    dc = done_cnt;
    for (int k = 0; k < 6; k++)
      beat(8'h60 + DW'(k), k == 0, k == 3, 0);
    send_frame(8'h70, 0);
    @(negedge clock);
    checks++;
    if (frame_done !== 1'b1 || in_ready !== 1'b0) begin
      fails++;
      $display("FAIL ms_done done/ready=%b%b required=10", frame_done, in_ready);
    end
    @(negedge clock);
    checks++;
    if ({frame_done, busy, in_ready} !== 3'b011) begin
      fails++;
      $display("FAIL ms_rearm done/busy/ready=%b required=011",
               {frame_done, busy, in_ready});
    end
    checks++;
    if (log_a.size() - b != 18 || log_a[b+6] !== '0 || log_d[b+6] !== 8'h70
        || log_a[b+17] !== AW'(11) || log_d[b+17] !== 8'h7B) begin
      fails++;
      $display("FAIL ms_writes n=%0d a6=%0d d6=%0h required=18/0/70",
               log_a.size() - b, log_a[b+6], log_d[b+6]);
    end
    checks++;
    if (line_error !== 1'b1 || done_cnt - dc != 1) begin
      fails++;
      $display("FAIL ms_flag err=%b done=%0d required=1/1",
               line_error, done_cnt - dc);
    end
  endtask

  task automatic test_back_to_back;
    int b, dc, bad;
    b   = log_a.size();
    dc  = done_cnt;
    bad = 0;
    send_frame(8'h80, 0);
    send_frame(8'h90, 0);
    repeat (3) @(negedge clock);
    for (int i = 0; i < 24; i++)
      if (log_a[b+i] !== AW'(i % 12) || log_d[b+i] !== 8'h80 + DW'(i % 12)
          + DW'(16 * (i / 12))) bad++;
    checks++;
    if (log_a.size() - b != 24 || bad != 0) begin
      fails++;
      $display("FAIL b2b_writes n=%0d bad=%0d required=24/0",
               log_a.size() - b, bad);
    end
    checks++;
    if (done_cnt - dc != 2 || line_error !== 1'b1 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL b2b_state done=%0d err=%b ready=%b required=2/1/1",
               done_cnt - dc, line_error, in_ready);
    end
    continuous = 1'b0;
  endtask

  task automatic test_async_reset;
    int b, dc, bad;
    for (int k = 0; k < 5; k++)
      beat(8'hC0 + DW'(k), k == 0, k == 3, 0);
    #1;
    checks++;
    if (we !== 1'b1 || busy !== 1'b1) begin
      fails++;
      $display("FAIL ar_pre we/busy=%b%b required=11", we, busy);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({we, busy, in_ready, line_error} !== 4'b0 || wraddress[AW-1:0] !== '0) begin
      fails++;
      $display("FAIL ar_now we/busy/ready/err=%b addr=%0d required=0000/0",
               {we, busy, in_ready, line_error}, wraddress[AW-1:0]);
    end
`ifdef IMAGE_DOUBLE_BUFFER_EN
    checks++;
    if (bank_sel !== 1'b0 || rd_bank !== 1'b1) begin
      fails++;
      $display("FAIL ar_bank got=%b%b required=01", bank_sel, rd_bank);
    end
`endif
    @(negedge clock) reset_n = 1'b1;
    b   = log_a.size();
    dc  = done_cnt;
    bad = 0;
    pulse_start;
    send_frame(8'hD0, 0);
    repeat (3) @(negedge clock);
    for (int i = 0; i < 12; i++)
      if (log_a[b+i] !== AW'(i) || log_d[b+i] !== 8'hD0 + DW'(i)) bad++;
    checks++;
    if (log_a.size() - b != 12 || bad != 0 || done_cnt - dc != 1) begin
      fails++;
      $display("FAIL ar_frame n=%0d bad=%0d done=%0d required=12/0/1",
               log_a.size() - b, bad, done_cnt - dc);
    end
`ifdef IMAGE_DOUBLE_BUFFER_EN
    checks++;
    if (bank_sel !== 1'b1 || rd_bank !== 1'b0) begin
      fails++;
      $display("FAIL ar_toggle got=%b%b required=10", bank_sel, rd_bank);
    end
`endif
  endtask

  initial begin
    test_reset;
    test_nominal;
    test_junk;
    test_backpressure;
    test_early_eol;
    test_midsof_cont;
    test_back_to_back;
    test_async_reset;
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
